// File: rtl/cu_fsm_if.sv
// Signal bundle between the OTTER control-unit sequencer and its surroundings:
// instruction fields and interrupt inputs in, datapath/CSR write strobes out.
interface cu_fsm_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       mie;
    logic       pcWrite;
    logic       regWrite;
    logic       memWE2;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       reset;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;

    modport master (
        output opcode, func3, intr, mie,
        input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );

    modport slave (
        input  opcode, func3, intr, mie,
        output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               reset, csr_WE, int_taken, mret_exec
    );
endinterface

// File: rtl/cu_fsm.sv
// Multi-cycle OTTER control sequencer: FETCH/EXEC (+WB for loads), with an
// interrupt-entry cycle inserted only at instruction boundaries.
module cu_fsm (
    input  logic     CLK,
    input  logic     RST,
    cu_fsm_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t state_q, state_d;
    logic   intr_pend_q, intr_pend_d;
    logic   take_intr;

    logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
    logic reset_o, csr_we, int_taken, mret_exec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_INIT;
            intr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            intr_pend_q <= intr_pend_d;
        end
    end

    // mie is sampled in the deciding cycle, so an MRET restoring it does not divert itself.
    assign take_intr = intr_pend_q & bus.mie;

    // A new request on the edge leaving INTR wins over the clear.
    assign intr_pend_d = bus.intr | (intr_pend_q & (state_q != ST_INTR));

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_we2   = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        reset_o   = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;

        case (state_q)
            ST_INIT: begin
                reset_o = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_rden1 = 1'b1;
                state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = take_intr ? ST_INTR : ST_FETCH;
                case (bus.opcode)
                    OPC_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_d   = ST_WB;
                    end
                    OPC_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                    end
                    OPC_BRANCH: pc_write = 1'b1;
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        pc_write = 1'b1;
                        if (bus.func3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    default: pc_write = 1'b1;
                endcase
            end

            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = take_intr ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_INIT;
        endcase
    end

    assign bus.pcWrite   = pc_write;
    assign bus.regWrite  = reg_write;
    assign bus.memWE2    = mem_we2;
    assign bus.memRDEN1  = mem_rden1;
    assign bus.memRDEN2  = mem_rden2;
    assign bus.reset     = reset_o;
    assign bus.csr_WE    = csr_we;
    assign bus.int_taken = int_taken;
    assign bus.mret_exec = mret_exec;
endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: walks instruction sequences cycle by cycle and
// compares the packed output strobes against hand-computed vectors.
module tb_cu_fsm;
    logic CLK = 1'b0;
    logic RST;

    cu_fsm_if bus ();

    cu_fsm u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
    localparam logic [8:0] O_NONE = 9'b0_0000_0000;
    localparam logic [8:0] O_PC   = 9'b1_0000_0000;
    localparam logic [8:0] O_RW   = 9'b0_1000_0000;
    localparam logic [8:0] O_WE2  = 9'b0_0100_0000;
    localparam logic [8:0] O_RD1  = 9'b0_0010_0000;
    localparam logic [8:0] O_RD2  = 9'b0_0001_0000;
    localparam logic [8:0] O_RST  = 9'b0_0000_1000;
    localparam logic [8:0] O_CSR  = 9'b0_0000_0100;
    localparam logic [8:0] O_INT  = 9'b0_0000_0010;
    localparam logic [8:0] O_MRET = 9'b0_0000_0001;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SYS   = 7'b1110011;
    localparam logic [6:0] NOPOP = 7'b0000000;

    logic [8:0] outs;
    assign outs = {bus.pcWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                   bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Inputs are already set (posedge+1); sample at negedge, then advance to next posedge+1.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge CLK);
        check_eq(tag, outs, exp);
        @(posedge CLK);
        #1;
    endtask

    logic [6:0] op_tab  [7];
    logic [8:0] exp_tab [7];

    initial begin
        op_tab[0] = 7'b1100011; exp_tab[0] = O_PC;          // BRANCH
        op_tab[1] = 7'b0110111; exp_tab[1] = O_RW | O_PC;   // LUI
        op_tab[2] = 7'b0010111; exp_tab[2] = O_RW | O_PC;   // AUIPC
        op_tab[3] = 7'b1101111; exp_tab[3] = O_RW | O_PC;   // JAL
        op_tab[4] = 7'b1100111; exp_tab[4] = O_RW | O_PC;   // JALR
        op_tab[5] = 7'b0110011; exp_tab[5] = O_RW | O_PC;   // OP
        op_tab[6] = 7'b1111111; exp_tab[6] = O_PC;          // unknown -> NOP

        RST = 1'b1;
        bus.opcode = NOPOP;
        bus.func3  = 3'b000;
        bus.intr   = 1'b0;
        bus.mie    = 1'b0;

        @(posedge CLK);
        #1;
        check_eq("reset_hold", outs, O_RST);
        RST = 1'b0;
        cyc("init", O_RST);

        // ADDI then SW
        bus.opcode = ADDI;
        cyc("addi_fetch", O_RD1);
        cyc("addi_exec", O_RW | O_PC);
        bus.opcode = SW;
        cyc("sw_fetch", O_RD1);
        cyc("sw_exec", O_WE2 | O_PC);

        // LW: three cycles
        bus.opcode = LW;
        cyc("lw_fetch", O_RD1);
        cyc("lw_exec", O_RD2);
        cyc("lw_wb", O_RW | O_PC);

        // Remaining opcode classes, no interrupts
        for (int i = 0; i < 7; i++) begin
            bus.opcode = op_tab[i];
            cyc($sformatf("tab%0d_fetch", i), O_RD1);
            cyc($sformatf("tab%0d_exec", i), exp_tab[i]);
        end

        // Reset mid-EXEC of ADDI, with a masked request pending that must be discarded
        bus.opcode = ADDI;
        bus.intr   = 1'b1;
        cyc("rst_addi_fetch", O_RD1);
        bus.intr   = 1'b0;
        @(negedge CLK);
        check_eq("rst_addi_exec", outs, O_RW | O_PC);
        #1;
        RST = 1'b1;
        #1;
        check_eq("rst_async", outs, O_RST);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.mie = 1'b1;
        cyc("rst_init", O_RST);
        cyc("rst_post_fetch", O_RD1);
        cyc("rst_post_exec", O_RW | O_PC);
        cyc("rst_no_intr", O_RD1);      // ADDI fetch, not INTR: pend discarded
        cyc("int_addi_exec0", O_RW | O_PC);

        // Interrupt taken: pulse during FETCH
        bus.intr = 1'b1;
        cyc("int_fetch", O_RD1);
        bus.intr = 1'b0;
        cyc("int_exec", O_RW | O_PC);
        cyc("int_intr", O_INT | O_PC);
        cyc("int_next_fetch", O_RD1);
        cyc("int_next_exec", O_RW | O_PC);

        // Masked interrupt survives three instructions
        bus.mie  = 1'b0;
        bus.intr = 1'b1;
        cyc("msk_fetch0", O_RD1);
        bus.intr = 1'b0;
        cyc("msk_exec0", O_RW | O_PC);
        for (int i = 1; i < 3; i++) begin
            cyc($sformatf("msk_fetch%0d", i), O_RD1);
            cyc($sformatf("msk_exec%0d", i), O_RW | O_PC);
        end
        bus.opcode = SYS;
        bus.func3  = 3'b010;
        cyc("csrrs_fetch", O_RD1);
        cyc("csrrs_exec", O_CSR | O_RW | O_PC);
        bus.mie    = 1'b1;
        bus.opcode = ADDI;
        bus.func3  = 3'b000;
        cyc("msk_fetch_en", O_RD1);
        cyc("msk_exec_en", O_RW | O_PC);
        cyc("msk_intr", O_INT | O_PC);

        // MRET with pending request and mie=0: no diversion
        bus.mie    = 1'b0;
        bus.opcode = SYS;
        bus.func3  = 3'b000;
        bus.intr   = 1'b1;
        cyc("mret_fetch", O_RD1);
        bus.intr   = 1'b0;
        cyc("mret_exec", O_MRET | O_PC);
        bus.opcode = NOPOP;
        cyc("mret_next_fetch", O_RD1);
        bus.mie    = 1'b1;
        cyc("nop_exec", O_PC);
        bus.intr   = 1'b1;              // pulse in INTR re-arms the flag
        cyc("mret_late_intr", O_INT | O_PC);
        bus.intr   = 1'b0;
        bus.opcode = ADDI;
        cyc("rearm_fetch", O_RD1);
        cyc("rearm_exec", O_RW | O_PC);
        cyc("rearm_intr", O_INT | O_PC);
        cyc("rearm_done_fetch", O_RD1);
        cyc("rearm_done_exec", O_RW | O_PC);
        cyc("rearm_cleared", O_RD1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
